// File: rtl/pdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pdu_pkg: shared state encoding and defaults for the run controller |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pdu_pkg;

    localparam int unsigned c_db_cycles_default = 1000000;

    typedef enum logic [2:0] {
        PAUSED = 3'd0,
        STEP_H = 3'd1,
        STEP_L = 3'd2,
        RUN_H  = 3'd3,
        RUN_L  = 3'd4
    } state_t;

    // H states are the only ones in which the CPU clock is high.
    function automatic logic is_high_state(input state_t s);
        return (s == STEP_H) || (s == RUN_H);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdu_btn_db.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pdu_btn_db: button synchroniser, debouncer and press-pulse source  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pdu_btn_db
    import pdu_pkg::*;
#(
    parameter int unsigned DB_CYCLES = c_db_cycles_default
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned        c_cnt_w    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            // Counter only runs while the input disagrees with the accepted level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/pdu_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pdu_run_ctrl: pause/step/run controller generating the CPU clock   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pdu_run_ctrl
    import pdu_pkg::*;
#(
    parameter int unsigned DB_CYCLES = c_db_cycles_default,
    parameter int unsigned PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step,
    input  logic            cont,
    input  logic            brk_en,
    input  logic [PC_W-1:0] brk_pc,
    input  logic [PC_W-1:0] pc,
    output logic            clk_cpu,
    output logic            pause,
    output logic [31:0]     cpu_cycles
);

    logic   w_step_level;
    logic   w_cont_level;
    logic   w_step_press;
    logic   w_cont_press;
    logic   w_unused_levels;
    logic   w_brk_hit;
    logic   w_enter_h;
    logic   w_in_run;
    state_t r_state;
    state_t w_next;
    logic   r_stop_req;
    logic   r_clk_cpu;
    logic   r_pause;
    logic [31:0] r_cpu_cycles;

    pdu_btn_db #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (step),
        .level (w_step_level),
        .press (w_step_press)
    );

    pdu_btn_db #(.DB_CYCLES(DB_CYCLES)) u_cont_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (cont),
        .level (w_cont_level),
        .press (w_cont_press)
    );

    assign w_unused_levels = w_step_level ^ w_cont_level;

    // pc is only consulted in RUN_L, i.e. after the current tick's CPU edge.
    assign w_brk_hit = brk_en && (pc == brk_pc);
    assign w_in_run  = (r_state == RUN_H) || (r_state == RUN_L);
    assign w_enter_h = is_high_state(w_next) && !is_high_state(r_state);

    always_comb begin
        w_next = r_state;
        case (r_state)
            PAUSED: begin
                if (w_cont_press) begin
                    w_next = RUN_H;
                end else if (w_step_press) begin
                    w_next = STEP_H;
                end
            end
            STEP_H:  w_next = STEP_L;
            STEP_L:  w_next = PAUSED;
            RUN_H:   w_next = RUN_L;
            RUN_L: begin
                if (r_stop_req || w_brk_hit) begin
                    w_next = PAUSED;
                end else begin
                    w_next = RUN_H;
                end
            end
            default: w_next = PAUSED;
        endcase
    end

    // Outputs are registered from the next state so clk_cpu has no combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= PAUSED;
            r_clk_cpu    <= 1'b0;
            r_pause      <= 1'b1;
            r_stop_req   <= 1'b0;
            r_cpu_cycles <= '0;
        end else begin
            r_state   <= w_next;
            r_clk_cpu <= is_high_state(w_next);
            r_pause   <= (w_next == PAUSED);
            if (w_next == PAUSED) begin
                r_stop_req <= 1'b0;
            end else if (w_cont_press && w_in_run) begin
                r_stop_req <= 1'b1;
            end
            if (w_enter_h && (r_cpu_cycles != '1)) begin
                r_cpu_cycles <= r_cpu_cycles + 32'd1;
            end
        end
    end

    assign clk_cpu    = r_clk_cpu;
    assign pause      = r_pause;
    assign cpu_cycles = r_cpu_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pdu_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pdu_run_ctrl: scoreboard bench for the run/step controller      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pdu_run_ctrl;

    typedef struct {
        int          min_t;
        int          max_t;
        logic [31:0] cyc;
        bit          cyc_known;
    } halt_exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0;
    logic        cont = 1'b0;
    logic        brk_en = 1'b0;
    logic [31:0] brk_pc = 32'd0;
    logic [31:0] pc;
    logic        clk_cpu;
    logic        pause;
    logic [31:0] cpu_cycles;

    int unsigned tick_cnt = 0;
    int unsigned tick_base = 0;
    logic [31:0] pc_base = 32'd0;

    halt_exp_t sb[$];
    chk_t      cq[$];
    int        n_cmp = 0;
    int        n_bad = 0;

    pdu_run_ctrl #(.DB_CYCLES(4), .PC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .cont       (cont),
        .brk_en     (brk_en),
        .brk_pc     (brk_pc),
        .pc         (pc),
        .clk_cpu    (clk_cpu),
        .pause      (pause),
        .cpu_cycles (cpu_cycles)
    );

    always #5 clk = ~clk;

    // CPU model: fetch PC advances by 4 on every CPU clock edge.
    always @(posedge clk_cpu) tick_cnt <= tick_cnt + 1;
    assign pc = pc_base + 32'(4 * (tick_cnt - tick_base));

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
        end
    endtask

    // Monitor: drains queued spot checks and scores every halt against the scoreboard.
    initial begin : monitor
        int        ep_ticks;
        int        ep_low;
        int        total;
        logic      prev_clk;
        logic      prev_pause;
        logic      prev_rst;
        chk_t      c;
        halt_exp_t e;
        ep_ticks = 0; ep_low = 0; total = 0;
        prev_clk = 1'b0; prev_pause = 1'b1; prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            while (cq.size() > 0) begin
                c = cq.pop_front();
                cmp(c.name, c.act, c.req);
            end
            if (rst) begin
                ep_ticks = 0; ep_low = 0; total = 0;
                prev_clk = 1'b0; prev_pause = 1'b1; prev_rst = 1'b1;
            end else begin
                if (prev_rst) begin
                    cmp("reset_clk_cpu", 32'(clk_cpu), 32'd0);
                    cmp("reset_pause", 32'(pause), 32'd1);
                    cmp("reset_cpu_cycles", cpu_cycles, 32'd0);
                end
                if (clk_cpu && !prev_clk) begin
                    ep_ticks++;
                    total++;
                end
                if (!pause) ep_low++;
                if (!pause && !prev_pause)
                    cmp("clk_cpu_alternates", 32'(clk_cpu), 32'(!prev_clk));
                if (pause && !prev_pause) begin
                    if (sb.size() == 0) begin
                        cmp("unexpected_halt", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        cmp($sformatf("halt_ticks(%0d in %0d..%0d)", ep_ticks, e.min_t, e.max_t),
                            32'(ep_ticks >= e.min_t && ep_ticks <= e.max_t), 32'd1);
                        cmp("halt_cpu_cycles", cpu_cycles, e.cyc_known ? e.cyc : 32'(total));
                        cmp("halt_pause_low_len", 32'(ep_low), 32'(2 * ep_ticks));
                        cmp("halt_clk_cpu_low", 32'(clk_cpu), 32'd0);
                    end
                    ep_ticks = 0;
                    ep_low   = 0;
                end
                prev_clk   = clk_cpu;
                prev_pause = pause;
                prev_rst   = 1'b0;
            end
        end
    end

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_chk(input string n, input logic [31:0] a, input logic [31:0] r);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.req  = r;
        cq.push_back(c);
    endtask

    task automatic expect_halt(input int mn, input int mx, input logic [31:0] cyc, input bit known);
        halt_exp_t e;
        e.min_t     = mn;
        e.max_t     = mx;
        e.cyc       = cyc;
        e.cyc_known = known;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tk(3);
        rst = 1'b0;
        tick_base = tick_cnt;
        pc_base   = 32'd0;
        tk(2);
    endtask

    task automatic press(input bit s, input bit c, input int hold);
        step = s;
        cont = c;
        tk(hold);
        step = 1'b0;
        cont = 1'b0;
        tk(10);
    endtask

    task automatic drain(input string n, input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            tk(1);
            i++;
        end
        if (sb.size() != 0) begin
            push_chk({n, "_halt_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin : stim
        bit found;
        tk(1);
        do_reset();

        // Single step
        expect_halt(1, 1, 32'd1, 1'b1);
        press(1'b1, 1'b0, 10);
        drain("step", 40);

        // Bouncing step never reaches the stability threshold
        do_reset();
        step = 1'b1; tk(2); step = 1'b0; tk(2);
        step = 1'b1; tk(2); step = 1'b0; tk(2);
        tk(15);
        push_chk("bounce_cpu_cycles", cpu_cycles, 32'd0);
        push_chk("bounce_pause", 32'(pause), 32'd1);

        // Run then stop with a second cont press
        do_reset();
        expect_halt(10, 40, 32'd0, 1'b0);
        press(1'b0, 1'b1, 8);
        tk(20);
        press(1'b0, 1'b1, 8);
        drain("run_stop", 60);

        // Breakpoint at 0x10, then resume from the breakpoint address
        do_reset();
        brk_en = 1'b1;
        brk_pc = 32'h0000_0010;
        expect_halt(4, 4, 32'd4, 1'b1);
        press(1'b0, 1'b1, 8);
        drain("brk", 60);
        push_chk("brk_pc_at_halt", pc, 32'h0000_0010);
        expect_halt(5, 40, 32'd0, 1'b0);
        press(1'b0, 1'b1, 8);
        press(1'b0, 1'b1, 8);
        drain("brk_resume", 60);
        brk_en = 1'b0;

        // Simultaneous step and cont: run wins
        do_reset();
        expect_halt(5, 40, 32'd0, 1'b0);
        press(1'b1, 1'b1, 8);
        press(1'b0, 1'b1, 8);
        drain("both", 60);

        // Asynchronous reset while in RUN_H
        do_reset();
        cont  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tk(1);
            if (clk_cpu) begin
                found = 1'b1;
                break;
            end
        end
        push_chk("run_h_reached", 32'(found), 32'd1);
        rst  = 1'b1;
        cont = 1'b0;
        #1;
        push_chk("async_rst_clk_cpu", 32'(clk_cpu), 32'd0);
        push_chk("async_rst_pause", 32'(pause), 32'd1);
        push_chk("async_rst_cpu_cycles", cpu_cycles, 32'd0);
        tk(2);
        rst = 1'b0;
        tk(12);
        push_chk("post_rst_pause", 32'(pause), 32'd1);
        push_chk("post_rst_cpu_cycles", cpu_cycles, 32'd0);

        // Saturation of the cycle counter
        do_reset();
        force dut.r_cpu_cycles = 32'hFFFF_FFFD;
        tk(1);
        release dut.r_cpu_cycles;
        tk(1);
        push_chk("preload_cpu_cycles", cpu_cycles, 32'hFFFF_FFFD);
        expect_halt(1, 1, 32'hFFFF_FFFE, 1'b1);
        press(1'b1, 1'b0, 10);
        drain("sat_step1", 40);
        expect_halt(1, 1, 32'hFFFF_FFFF, 1'b1);
        press(1'b1, 1'b0, 10);
        drain("sat_step2", 40);
        expect_halt(1, 1, 32'hFFFF_FFFF, 1'b1);
        press(1'b1, 1'b0, 10);
        drain("sat_step3", 40);
        expect_halt(5, 40, 32'hFFFF_FFFF, 1'b1);
        press(1'b0, 1'b1, 8);
        press(1'b0, 1'b1, 8);
        drain("sat_run", 60);

        tk(3);
        push_chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        tk(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
